// File: rtl/uart_tx_core.sv
// UART transmitter with load / stage / start host handshake; start bit, LSB-first data, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data MSB and the stop bit.
module uart_tx_core #(
    parameter int unsigned DVSR      = 174,
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [WORD_SIZE-1:0] dataBus,
    input  logic                 ldXmtDataReg,
    input  logic                 byteReady,
    input  logic                 tByte,
    output logic                 serialOut,
    output logic                 txDone
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = WORD_SIZE + 3;
`else
    localparam int unsigned FRAME_BITS = WORD_SIZE + 2;
`endif
    localparam int unsigned SHIFT_W = FRAME_BITS;
    localparam int unsigned BAUD_W  = $clog2(DVSR);
    localparam int unsigned BIT_W   = $clog2(WORD_SIZE + 3);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAITING = 2'd1,
        S_SENDING = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 sout_q, sout_d;
    logic                 txdone_q, txdone_d;

    logic                 baud_wrap_c;
    logic                 last_bit_c;
    logic [SHIFT_W-1:0]   frame_c;

    assign baud_wrap_c = (baud_q == BAUD_W'(DVSR - 1));
    assign last_bit_c  = (bit_q == BIT_W'(FRAME_BITS - 1));

    // Frame image shifted out LSB first: start bit in bit 0, stop bit on top.
`ifdef UART_TX_PARITY_EN
    assign frame_c = {1'b1, ^data_q, data_q, 1'b0};
`else
    assign frame_c = {1'b1, data_q, 1'b0};
`endif

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; byteReady has priority over tByte while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (byteReady) state_d = S_WAITING;
            S_WAITING: if (tByte) state_d = S_SENDING;
            S_SENDING: if (baud_wrap_c && last_bit_c) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        data_d   = ldXmtDataReg ? dataBus : data_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sout_d   = 1'b1;
        txdone_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (byteReady) shift_d = frame_c;
            end
            S_WAITING: begin
                if (byteReady) shift_d = frame_c;
                if (tByte) begin
                    baud_d = '0;
                    bit_d  = '0;
                    sout_d = 1'b0;
                end
            end
            S_SENDING: begin
                sout_d = shift_q[0];
                if (baud_wrap_c) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[SHIFT_W-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    sout_d  = shift_q[1];
                    if (last_bit_c) begin
                        sout_d   = 1'b1;
                        txdone_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                sout_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            data_q   <= '0;
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            sout_q   <= 1'b1;
            txdone_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sout_q   <= sout_d;
            txdone_q <= txdone_d;
        end
    end

    assign serialOut = sout_q;
    assign txDone    = txdone_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frames compared against a bit-list model of the UART frame.
module tb_uart_tx_core;

    localparam int unsigned DVSR = 174;
    localparam int unsigned W    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = W + 3;
`else
    localparam int unsigned FB = W + 2;
`endif
    localparam int NS = FB * DVSR + 1;

    logic         clk = 1'b0;
    logic         nRST = 1'b0;
    logic [W-1:0] dataBus = '0;
    logic         ldXmtDataReg = 1'b0;
    logic         byteReady = 1'b0;
    logic         tByte = 1'b0;
    logic         serialOut;
    logic         txDone;

    int n_checks = 0;
    int n_pass   = 0;

    logic obs_line [NS];
    logic obs_done [NS];
    int   done_at;
    int   done_cnt;

    uart_tx_core #(.DVSR(DVSR), .WORD_SIZE(W)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .dataBus     (dataBus),
        .ldXmtDataReg(ldXmtDataReg),
        .byteReady   (byteReady),
        .tByte       (tByte),
        .serialOut   (serialOut),
        .txDone      (txDone)
    );

    always #5 clk = ~clk;

    // Reference: frame bit n of a byte (start, data LSB first, optional parity, stop).
    function automatic logic frame_bit(input logic [W-1:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= int'(W)) return b[n-1];
`ifdef UART_TX_PARITY_EN
        if (n == int'(W) + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    // Number of captured cycles disagreeing with the model line and done pulse.
    function automatic int line_errors(input logic [W-1:0] b);
        int errs = 0;
        for (int i = 0; i < NS; i++) begin
            logic exp_line;
            logic exp_done;
            exp_line = (i < NS - 1) ? frame_bit(b, i / int'(DVSR)) : 1'b1;
            exp_done = (i == NS - 1);
            if (obs_line[i] !== exp_line || obs_done[i] !== exp_done) errs++;
        end
        return errs;
    endfunction

    task automatic drive_load(input logic [W-1:0] b);
        dataBus = b;
        ldXmtDataReg = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ldXmtDataReg = 1'b0;
    endtask

    task automatic drive_stage();
        byteReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        byteReady = 1'b0;
    endtask

    // Pulse tByte, then record line and done for every cycle up to the expected done cycle.
    task automatic capture_frame(input bit mid_load, input logic [W-1:0] mid_byte);
        tByte = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tByte = 1'b0;
        done_at  = -1;
        done_cnt = 0;
        for (int i = 0; i < NS; i++) begin
            obs_line[i] = serialOut;
            obs_done[i] = txDone;
            if (txDone === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (mid_load && i == 4 * int'(DVSR)) begin
                dataBus = mid_byte;
                ldXmtDataReg = 1'b1;
            end
            if (mid_load && i == 4 * int'(DVSR) + 1) ldXmtDataReg = 1'b0;
            if (i < NS - 1) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (serialOut !== 1'b1 || txDone !== 1'b0)
            $display("FAIL reset_values: serialOut=%b txDone=%b expected 1/0", serialOut, txDone);
        else n_pass++;
        nRST = 1'b1;
        @(negedge clk);
        n_checks++;
        if (serialOut !== 1'b1 || txDone !== 1'b0)
            $display("FAIL post_reset_idle: serialOut=%b txDone=%b expected 1/0", serialOut, txDone);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [W-1:0] b = 8'hAB;
        drive_load(b);
        drive_stage();
        capture_frame(1'b0, '0);
        for (int n = 0; n < int'(FB); n++) begin
            logic got;
            got = obs_line[n * int'(DVSR) + int'(DVSR) / 2];
            n_checks++;
            if (got !== frame_bit(b, n))
                $display("FAIL basic_bit%0d: got %b expected %b", n, got, frame_bit(b, n));
            else n_pass++;
        end
        n_checks++;
        if (line_errors(b) !== 0)
            $display("FAIL basic_line: %0d bad cycles expected 0", line_errors(b));
        else n_pass++;
        n_checks++;
        if (done_at !== int'(FB * DVSR) || done_cnt !== 1)
            $display("FAIL basic_done: at %0d count %0d expected at %0d count 1", done_at, done_cnt, FB * DVSR);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seq [5];
        seq[0] = 8'hA1; seq[1] = 8'hA1; seq[2] = 8'hA0; seq[3] = 8'hD1; seq[4] = 8'hD0;
        for (int k = 0; k < 5; k++) begin
            drive_load(seq[k]);
            n_checks++;
            if (serialOut !== 1'b1 || txDone !== 1'b0)
                $display("FAIL b2b_gap%0d: serialOut=%b txDone=%b expected 1/0", k, serialOut, txDone);
            else n_pass++;
            drive_stage();
            capture_frame(1'b0, '0);
            n_checks++;
            if (line_errors(seq[k]) !== 0 || done_cnt !== 1)
                $display("FAIL b2b_frame%0d: %0d bad cycles, %0d done pulses expected 0 and 1",
                         k, line_errors(seq[k]), done_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_order();
        int lows = 0;
        logic [W-1:0] b = 8'h3C;
        @(negedge clk);
        tByte = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tByte = 1'b0;
        for (int i = 0; i < 2 * int'(DVSR); i++) begin
            if (serialOut !== 1'b1 || txDone !== 1'b0) lows++;
            @(negedge clk);
        end
        n_checks++;
        if (lows !== 0) $display("FAIL tbyte_in_idle: %0d active cycles expected 0", lows);
        else n_pass++;
        drive_load(b);
        byteReady = 1'b1;
        tByte = 1'b1;
        @(posedge clk);
        @(negedge clk);
        byteReady = 1'b0;
        tByte = 1'b0;
        lows = 0;
        for (int i = 0; i < int'(DVSR); i++) begin
            if (serialOut !== 1'b1) lows++;
            @(negedge clk);
        end
        n_checks++;
        if (lows !== 0) $display("FAIL both_in_idle: %0d low cycles expected 0", lows);
        else n_pass++;
        capture_frame(1'b0, '0);
        n_checks++;
        if (line_errors(b) !== 0) $display("FAIL both_then_tbyte: %0d bad cycles expected 0", line_errors(b));
        else n_pass++;
    endtask

    task automatic test_load_during_send();
        drive_load(8'hAB);
        drive_stage();
        capture_frame(1'b1, 8'h55);
        n_checks++;
        if (line_errors(8'hAB) !== 0) $display("FAIL load_mid_current: %0d bad cycles expected 0", line_errors(8'hAB));
        else n_pass++;
        drive_stage();
        capture_frame(1'b0, '0);
        n_checks++;
        if (line_errors(8'h55) !== 0) $display("FAIL load_mid_next: %0d bad cycles expected 0", line_errors(8'h55));
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] b = 8'hD1;
        drive_load(b);
        drive_stage();
        tByte = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tByte = 1'b0;
        repeat (4 * DVSR + DVSR / 2) @(negedge clk);
        n_checks++;
        if (serialOut !== frame_bit(b, 4))
            $display("FAIL pre_reset_bit4: got %b expected %b", serialOut, frame_bit(b, 4));
        else n_pass++;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (serialOut !== 1'b1 || txDone !== 1'b0)
            $display("FAIL async_reset: serialOut=%b txDone=%b expected 1/0", serialOut, txDone);
        else n_pass++;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        drive_stage();
        capture_frame(1'b0, '0);
        n_checks++;
        if (line_errors('0) !== 0) $display("FAIL reset_clears_data: %0d bad cycles expected 0", line_errors('0));
        else n_pass++;
        drive_load(b);
        drive_stage();
        capture_frame(1'b0, '0);
        n_checks++;
        if (line_errors(b) !== 0 || done_at !== int'(FB * DVSR))
            $display("FAIL after_reset_frame: %0d bad cycles done at %0d expected 0 and %0d",
                     line_errors(b), done_at, FB * DVSR);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] b;
            b = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_load(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_stage();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            capture_frame(1'b0, '0);
            n_checks++;
            if (line_errors(b) !== 0 || done_cnt !== 1)
                $display("FAIL random_frame%0d byte %0h: %0d bad cycles, %0d done pulses expected 0 and 1",
                         k, b, line_errors(b), done_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_out_of_order();
        test_load_during_send();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
